// File: rtl/wb_pkg.sv
// Shared write-back definitions: source indices, zero register and the default entry layout.
package wb_pkg;

  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_REG_W  = 5;

  localparam int unsigned SRC_ALU   = 0;
  localparam int unsigned SRC_LS    = 1;
  localparam int unsigned SRC_HI    = 2;
  localparam int unsigned SRC_LO    = 3;
  localparam int unsigned SRC_SHIFT = 4;
  localparam int unsigned SRC_LT    = 5;

  localparam int unsigned ZERO_REG  = 0;

  typedef struct packed {
    logic [WB_DATA_W-1:0] data;
    logic [WB_REG_W-1:0]  dest;
    logic                 wr_en;
  } wb_entry_t;

endpackage

// File: rtl/wb_skid_fifo.sv
// Two-entry valid/ready buffer; head entry and both handshake flags are driven straight from flops.
module wb_skid_fifo
  import wb_pkg::*;
#(
  parameter type entry_t = wb_entry_t
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   in_valid,
  output logic   in_ready,
  input  entry_t in_entry,
  output logic   out_valid,
  input  logic   out_ready,
  output entry_t out_entry
);

  logic [1:0] count_q, count_d;
  entry_t     head_q, head_d;
  entry_t     tail_q, tail_d;
  logic       push, pop;

  // Head always holds the oldest entry; tail is only used when two are stored.
  always_comb begin
    push    = in_valid && in_ready;
    pop     = out_valid && out_ready;
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          head_d  = in_entry;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = in_entry;
        end else if (push) begin
          tail_d  = in_entry;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_d  = tail_q;
          count_d = 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q   <= 2'd0;
      head_q    <= '0;
      tail_q    <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      count_q   <= count_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      out_valid <= (count_d != 2'd0);
      in_ready  <= (count_d != 2'd2);
    end
  end

  assign out_entry = head_q;

endmodule

// File: rtl/wb_select_stage.sv
// Registered write-back selector: picks a source, tags it with the destination and
// buffers it for the register-file write port, tracking illegal selects.
module wb_select_stage
  import wb_pkg::*;
#(
  parameter  int unsigned DATA_W    = 32,
  parameter  int unsigned NUM_SRC   = 6,
  parameter  int unsigned REG_W     = 5,
  parameter  int unsigned ERR_CNT_W = 8,
  localparam int unsigned SEL_W     = $clog2(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [SEL_W-1:0]          sel,
  input  logic [REG_W-1:0]          dest_reg,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [REG_W-1:0]          out_reg,
  output logic                      out_wr_en,
  output logic                      sel_err,
  output logic [ERR_CNT_W-1:0]      err_cnt,
  input  logic                      clr_err
);

  localparam int unsigned SEL_N = 1 << SEL_W;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [REG_W-1:0]  dest;
    logic              wr_en;
  } entry_t;

  logic [DATA_W-1:0] src_arr [SEL_N];
  logic              sel_ok;
  logic              illegal_acc;
  entry_t            new_entry;
  entry_t            head;

  // Unused encodings read as zero so an illegal select carries zero data.
  for (genvar i = 0; i < int'(SEL_N); i++) begin : g_src
    if (i < int'(NUM_SRC)) begin : g_used
      assign src_arr[i] = src_data[i*DATA_W +: DATA_W];
    end else begin : g_unused
      assign src_arr[i] = '0;
    end
  end

  always_comb begin
    sel_ok          = (32'(sel) < NUM_SRC);
    illegal_acc     = in_valid && in_ready && !sel_ok;
    new_entry.data  = src_arr[sel];
    new_entry.dest  = dest_reg;
    new_entry.wr_en = sel_ok && (dest_reg != REG_W'(ZERO_REG));
  end

  wb_skid_fifo #(
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_entry  (new_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_entry (head)
  );

  assign out_data  = head.data;
  assign out_reg   = head.dest;
  assign out_wr_en = head.wr_en;

  // Clear applies first, then an illegal accept in the same cycle is counted afresh.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_err <= 1'b0;
      err_cnt <= '0;
    end else if (clr_err) begin
      sel_err <= illegal_acc;
      err_cnt <= illegal_acc ? ERR_CNT_W'(1) : '0;
    end else if (illegal_acc) begin
      sel_err <= 1'b1;
      if (err_cnt != '1) begin
        err_cnt <= err_cnt + ERR_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_select_stage.sv
// Directed bench for wb_select_stage: default 6-source instance plus an 8-source 64-bit instance.
module tb_wb_select_stage;

  logic clk;
  int   total;
  int   bad;

  // Instance A: defaults (DATA_W=32, NUM_SRC=6)
  logic         a_rst_n, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [191:0] a_src;
  logic [2:0]   a_sel;
  logic [4:0]   a_dest, a_out_reg;
  logic [31:0]  a_out_data;
  logic         a_out_wr_en, a_sel_err, a_clr;
  logic [7:0]   a_err_cnt;

  // Instance B: NUM_SRC=8, DATA_W=64
  logic         b_rst_n, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [511:0] b_src;
  logic [2:0]   b_sel;
  logic [4:0]   b_dest, b_out_reg;
  logic [63:0]  b_out_data;
  logic         b_out_wr_en, b_sel_err, b_clr;
  logic [7:0]   b_err_cnt;

  wb_select_stage u_a (
    .clk(clk), .reset_n(a_rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .src_data(a_src), .sel(a_sel), .dest_reg(a_dest), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .out_reg(a_out_reg),
    .out_wr_en(a_out_wr_en), .sel_err(a_sel_err), .err_cnt(a_err_cnt), .clr_err(a_clr)
  );

  wb_select_stage #(.DATA_W(64), .NUM_SRC(8)) u_b (
    .clk(clk), .reset_n(b_rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .src_data(b_src), .sel(b_sel), .dest_reg(b_dest), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_reg(b_out_reg),
    .out_wr_en(b_out_wr_en), .sel_err(b_sel_err), .err_cnt(b_err_cnt), .clr_err(b_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_in_valid = 1'b1; a_out_ready = 1'b1; a_clr = 1'b0;
    a_src = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    a_sel = 3'($urandom_range(0, 7)); a_dest = 5'($urandom);
    b_in_valid = 1'b1; b_out_ready = 1'b0; b_clr = 1'b0;
    b_src = '0; b_sel = 3'd7; b_dest = 5'd1;
    repeat (3) cyc();
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", a_out_valid); end
    total++; if (a_out_data !== 32'h0) begin bad++; $display("FAIL rst_data: got %h want 0", a_out_data); end
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", a_in_ready); end
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    cyc();
    total++; if (a_err_cnt !== 8'h0) begin bad++; $display("FAIL rst_errcnt: got %h want 0", a_err_cnt); end
    total++; if (a_sel_err !== 1'b0) begin bad++; $display("FAIL rst_selerr: got %b want 0", a_sel_err); end
    total++; if (a_out_valid !== 1'b0 || a_out_wr_en !== 1'b0 || a_out_reg !== 5'd0) begin
      bad++; $display("FAIL rst_post: got v=%b we=%b reg=%0d want 0 0 0", a_out_valid, a_out_wr_en, a_out_reg);
    end
  endtask

  task automatic test_source_sweep();
    for (int i = 0; i < 6; i++) a_src[i*32 +: 32] = 32'hA000_0000 + 32'(i);
    a_dest = 5'd8; a_out_ready = 1'b1; a_in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a_sel = 3'(i);
      cyc();
      total++; if (a_out_valid !== 1'b1 || a_out_data !== 32'hA000_0000 + 32'(i)) begin
        bad++; $display("FAIL sweep_data[%0d]: got v=%b %h want 1 %h", i, a_out_valid, a_out_data, 32'hA000_0000 + 32'(i));
      end
      total++; if (a_out_wr_en !== 1'b1 || a_out_reg !== 5'd8) begin
        bad++; $display("FAIL sweep_tag[%0d]: got we=%b reg=%0d want 1 8", i, a_out_wr_en, a_out_reg);
      end
    end
    a_in_valid = 1'b0;
    cyc();
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL sweep_drain: got %b want 0", a_out_valid); end
  endtask

  task automatic test_zero_reg();
    a_src[2*32 +: 32] = 32'hDEAD_BEEF;
    a_sel = 3'd2; a_dest = 5'd0; a_in_valid = 1'b1; a_out_ready = 1'b1;
    cyc();
    a_in_valid = 1'b0;
    total++; if (a_out_valid !== 1'b1 || a_out_data !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL zero_data: got v=%b %h want 1 deadbeef", a_out_valid, a_out_data);
    end
    total++; if (a_out_reg !== 5'd0 || a_out_wr_en !== 1'b0) begin
      bad++; $display("FAIL zero_wren: got reg=%0d we=%b want 0 0", a_out_reg, a_out_wr_en);
    end
    cyc();
  endtask

  task automatic test_back_pressure();
    logic [31:0] exp_d [3];
    logic [4:0]  exp_r [3];
    logic [2:0]  sels  [3];
    sels[0] = 3'd0; sels[1] = 3'd1; sels[2] = 3'd3;
    for (int i = 0; i < 6; i++) a_src[i*32 +: 32] = 32'h1111_0000 + 32'(i);
    for (int i = 0; i < 3; i++) begin
      exp_d[i] = 32'h1111_0000 + 32'(sels[i]);
      exp_r[i] = 5'(i + 1);
    end
    a_out_ready = 1'b0; a_in_valid = 1'b1;
    a_sel = sels[0]; a_dest = exp_r[0];
    cyc();
    total++; if (a_in_ready !== 1'b1 || a_out_data !== exp_d[0]) begin
      bad++; $display("FAIL bp_first: got rdy=%b %h want 1 %h", a_in_ready, a_out_data, exp_d[0]);
    end
    a_sel = sels[1]; a_dest = exp_r[1];
    cyc();
    total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL bp_full: got rdy=%b want 0", a_in_ready); end
    a_sel = sels[2]; a_dest = exp_r[2];
    repeat (2) begin
      cyc();
      total++; if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_out_data !== exp_d[0] || a_out_reg !== exp_r[0]) begin
        bad++; $display("FAIL bp_stall: got rdy=%b v=%b %h r=%0d want 0 1 %h %0d",
                        a_in_ready, a_out_valid, a_out_data, a_out_reg, exp_d[0], exp_r[0]);
      end
    end
    a_out_ready = 1'b1;
    cyc();
    total++; if (a_in_ready !== 1'b1 || a_out_data !== exp_d[1] || a_out_reg !== exp_r[1]) begin
      bad++; $display("FAIL bp_second: got rdy=%b %h r=%0d want 1 %h %0d", a_in_ready, a_out_data, a_out_reg, exp_d[1], exp_r[1]);
    end
    cyc();
    a_in_valid = 1'b0;
    total++; if (a_out_valid !== 1'b1 || a_out_data !== exp_d[2] || a_out_reg !== exp_r[2]) begin
      bad++; $display("FAIL bp_third: got v=%b %h r=%0d want 1 %h %0d", a_out_valid, a_out_data, a_out_reg, exp_d[2], exp_r[2]);
    end
    cyc();
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL bp_nodup: got v=%b want 0", a_out_valid); end
  endtask

  task automatic test_illegal_select();
    a_dest = 5'd5; a_out_ready = 1'b1; a_clr = 1'b0; a_in_valid = 1'b1;
    a_sel = 3'd6;
    cyc();
    total++; if (a_out_data !== 32'h0 || a_out_wr_en !== 1'b0 || a_out_valid !== 1'b1) begin
      bad++; $display("FAIL ill6_entry: got v=%b %h we=%b want 1 0 0", a_out_valid, a_out_data, a_out_wr_en);
    end
    a_sel = 3'd7;
    cyc();
    a_in_valid = 1'b0;
    total++; if (a_sel_err !== 1'b1 || a_err_cnt !== 8'd2) begin
      bad++; $display("FAIL ill_count: got err=%b cnt=%0d want 1 2", a_sel_err, a_err_cnt);
    end
    cyc();
    a_clr = 1'b1; a_in_valid = 1'b1; a_sel = 3'd6;
    cyc();
    a_in_valid = 1'b0;
    total++; if (a_sel_err !== 1'b1 || a_err_cnt !== 8'd1) begin
      bad++; $display("FAIL ill_clr_same: got err=%b cnt=%0d want 1 1", a_sel_err, a_err_cnt);
    end
    cyc();
    a_clr = 1'b0;
    total++; if (a_sel_err !== 1'b0 || a_err_cnt !== 8'd0) begin
      bad++; $display("FAIL ill_clr: got err=%b cnt=%0d want 0 0", a_sel_err, a_err_cnt);
    end
    // Fill the buffer, then hold an illegal request while stalled: it must not count.
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_sel = 3'd1;
    repeat (2) cyc();
    a_sel = 3'd7;
    repeat (3) cyc();
    total++; if (a_err_cnt !== 8'd0 || a_sel_err !== 1'b0) begin
      bad++; $display("FAIL ill_stalled: got err=%b cnt=%0d want 0 0", a_sel_err, a_err_cnt);
    end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    repeat (3) cyc();
    // 260 consecutive illegal accepts saturate the counter.
    a_in_valid = 1'b1; a_sel = 3'd7;
    repeat (260) cyc();
    a_in_valid = 1'b0;
    total++; if (a_err_cnt !== 8'hFF || a_sel_err !== 1'b1) begin
      bad++; $display("FAIL ill_saturate: got err=%b cnt=%0d want 1 255", a_sel_err, a_err_cnt);
    end
    repeat (2) cyc();
  endtask

  task automatic test_param_and_reset();
    for (int i = 0; i < 8; i++) b_src[i*64 +: 64] = 64'hB000_0000_0000_0000 + 64'(i);
    b_out_ready = 1'b1; b_in_valid = 1'b1; b_sel = 3'd7; b_dest = 5'd9;
    cyc();
    total++; if (b_out_valid !== 1'b1 || b_out_data !== 64'hB000_0000_0000_0007 || b_out_wr_en !== 1'b1) begin
      bad++; $display("FAIL p8_data: got v=%b %h we=%b want 1 b000000000000007 1", b_out_valid, b_out_data, b_out_wr_en);
    end
    total++; if (b_sel_err !== 1'b0 || b_err_cnt !== 8'd0) begin
      bad++; $display("FAIL p8_noerr: got err=%b cnt=%0d want 0 0", b_sel_err, b_err_cnt);
    end
    b_out_ready = 1'b0; b_sel = 3'd3; b_dest = 5'd4;
    cyc();
    b_in_valid = 1'b0;
    total++; if (b_in_ready !== 1'b0 || b_out_valid !== 1'b1 || b_out_data !== 64'hB000_0000_0000_0007) begin
      bad++; $display("FAIL p8_full: got rdy=%b v=%b %h want 0 1 b000000000000007", b_in_ready, b_out_valid, b_out_data);
    end
    #2 b_rst_n = 1'b0;
    #1;
    total++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1 || b_out_data !== 64'h0) begin
      bad++; $display("FAIL p8_async_rst: got v=%b rdy=%b %h want 0 1 0", b_out_valid, b_in_ready, b_out_data);
    end
    cyc();
    b_rst_n = 1'b1; b_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++; if (b_out_valid !== 1'b0) begin bad++; $display("FAIL p8_after_rst[%0d]: got v=%b want 0", i, b_out_valid); end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_source_sweep();
    test_zero_reg();
    test_back_pressure();
    test_illegal_select();
    test_param_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_select_stage.md
Name: wb_select_stage

Overview:
- Parametrised, registered write-back selector for the multicycle MIPS datapath.
- Picks one of NUM_SRC source buses (ALU, load/store, HI, LO, shifter, set-less-than, ...) with an encoded select.
- Tags the result with the destination register, suppresses writes to $zero and illegal selects, and delivers it through a 2-entry valid/ready buffer to the register-file write port.
- Replaces the old fixed 6-way combinational write-data mux.

Parameters:
- DATA_W, 32, width of each source and of out_data.
- NUM_SRC, 6, number of source buses; must be at least 2.
- SEL_W, $clog2(NUM_SRC), width of sel; derived localparam, not overridable.
- REG_W, 5, destination register index width.
- ERR_CNT_W, 8, width of the saturating illegal-select counter.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream offers a write-back request.
- in_ready  out  1  stage can accept; a transfer occurs when in_valid and in_ready are both high.
- src_data  in  NUM_SRC*DATA_W  packed sources; source i occupies bits [i*DATA_W +: DATA_W].
- sel  in  SEL_W  source index.
- dest_reg  in  REG_W  destination register.
- out_valid  out  1  head entry valid.
- out_ready  in  1  register file accepts the head entry.
- out_data  out  DATA_W  selected data of head entry.
- out_reg  out  REG_W  destination of head entry.
- out_wr_en  out  1  register-file write enable of head entry.
- sel_err  out  1  sticky flag: an illegal select was accepted.
- err_cnt  out  ERR_CNT_W  count of accepted illegal selects, saturating.
- clr_err  in  1  synchronous clear of sel_err and err_cnt.

Behaviour:
- Reset (async assert, sync release): buffer empty; out_valid=0, out_data=0, out_reg=0, out_wr_en=0, sel_err=0, err_cnt=0, in_ready=1.
- Selection at accept: data = source[sel] when sel < NUM_SRC; otherwise data=0 and wr_en=0.
- wr_en = (sel < NUM_SRC) && (dest_reg != 0). A $zero destination still passes data and reg through, with wr_en=0.
- The entry {data, dest_reg, wr_en} is written into a 2-entry FIFO on accept.
- Latency: an accept at edge N gives out_valid=1 after edge N when the buffer was empty. Outputs come from registers only; there is no combinational path from sel or src_data to the outputs.
- Occupancy count is 0..2.
- in_ready = (count < 2), registered, so there is no combinational path from out_ready to in_ready.
- Pop when out_valid && out_ready.
- Simultaneous push and pop at count=1: count stays 1 and the new entry becomes the head on the next cycle.
- Simultaneous push and pop at count=0: impossible, since out_valid=0.
- At count=2: in_ready=0 and in_valid is ignored; a pop that cycle restores in_ready=1 next cycle.
- Order is strictly FIFO.
- While out_valid=1 and out_ready=0, out_data, out_reg and out_wr_en hold stable.
- Error tracking: an illegal select is counted only on an actual accept, not while stalled.
  - sel_err sets on the edge of that accept.
  - err_cnt increments and saturates at all-ones.
  - If clr_err and an illegal accept occur in the same cycle, clr_err wins the clear and the new event then counts: sel_err=1, err_cnt=1.
- Reset mid-operation: buffer contents are discarded immediately and outputs return to reset values asynchronously.
- NUM_SRC as a power of two: no illegal encodings exist, so sel_err never sets.

Decomposition:
- Package wb_pkg holds:
  - source index constants SRC_ALU=0, SRC_LS=1, SRC_HI=2, SRC_LO=3, SRC_SHIFT=4, SRC_LT=5;
  - typedef wb_entry_t {data, dest, wr_en}, parametrised via DATA_W and REG_W defaults;
  - ZERO_REG=0.
- One sub-module, wb_skid_fifo: a 2-entry valid/ready FIFO of wb_entry_t with registered ready.
- Select, zero-register and error logic stay in wb_select_stage.

Test Plan:
- Reset: hold reset_n=0 with random inputs, then release -> out_valid=0, out_data=0, in_ready=1, err_cnt=0.
- Source sweep: sources i = 32'hA000_0000+i; push sel=0..5 with dest_reg=8, out_ready=1 -> out_data=A000_0000..A000_0005 in order, each one cycle after accept, out_wr_en=1.
- $zero suppression: sel=SRC_HI, HI=32'hDEAD_BEEF, dest_reg=0 -> out_data=DEAD_BEEF, out_reg=0, out_wr_en=0.
- Back-pressure: out_ready=0, push 3 requests back-to-back -> in_ready drops after the 2nd accept and the 3rd is held; raise out_ready -> three outputs in order, no loss or duplication, head stable while stalled.
- Illegal select: sel=6 and sel=7 accepted (NUM_SRC=6) -> out_data=0, out_wr_en=0, sel_err=1, err_cnt=2; clr_err together with a further illegal accept -> err_cnt=1.
- Parametrisation and mid-flight reset: NUM_SRC=8, DATA_W=64, sel=7 -> source 7 passes and sel_err stays 0; assert reset_n with 2 entries buffered -> out_valid=0 immediately, and nothing pops after release.
